// File: rtl/aes_kat_sequencer.sv
// AES known-answer-test sequencer.
// Steps through NUM_CH core channels: for each channel it pulses core_start,
// waits for core_done, compares core_result with exp_data and records the
// outcome. Results are shown on pass_led/all_pass once the run is complete
// and while enable stays high.
// Optional feature: define AES_KAT_TIMEOUT_EN to add a 16-bit wait counter
// that fails a channel whose core never answers within TIMEOUT cycles.
module aes_kat_sequencer #(
   parameter int unsigned NUM_CH  = 6,
   parameter int unsigned DATA_W  = 128,
   parameter int unsigned TIMEOUT = 1024,
   localparam int unsigned CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   output logic [CW-1:0]     ch_sel,
   output logic              core_start,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_result,
   input  logic [DATA_W-1:0] exp_data,
   output logic [NUM_CH-1:0] pass_led,
   output logic              all_pass,
   output logic              busy,
   output logic              done
);

   // Elaboration-time parameter range checks
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("aes_kat_sequencer: NUM_CH must be 1..8");
   end
   if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("aes_kat_sequencer: TIMEOUT must be 2..65535");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

   state_t            state_q, state_d;
   logic              en_q;
   logic              rise;
   logic [CW-1:0]     ch_q;
   logic [NUM_CH-1:0] result_q;
   logic              match_q;
   logic              in_done;
   logic              tmo_hit;

   assign rise = enable & ~en_q;

`ifdef AES_KAT_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;
   assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // State register and enable edge-detect flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= enable;
      end
   end

   // Next-state logic; dropping enable mid-run aborts to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (rise) state_d = S_START;
         S_START:        state_d = enable ? S_WAIT : S_IDLE;
         S_WAIT: begin
            if (!enable)                 state_d = S_IDLE;
            else if (core_done || tmo_hit) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!enable)              state_d = S_IDLE;
            else if (ch_q == LAST_CH) state_d = S_DONE;
            else                      state_d = S_START;
         end
         default:        state_d = S_IDLE;
      endcase
   end

   // Channel index, per-channel results, sampled match flag and wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q      <= '0;
         result_q  <= '0;
         match_q   <= 1'b0;
`ifdef AES_KAT_TIMEOUT_EN
         tmo_cnt_q <= '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (rise) begin
                  ch_q     <= '0;
                  result_q <= '0;
               end
            end
            S_START: begin
               if (!enable) result_q <= '0;
`ifdef AES_KAT_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
            end
            S_WAIT: begin
               if (!enable) begin
                  result_q <= '0;
               end else if (core_done) begin
                  match_q <= (core_result == exp_data);
               end else if (tmo_hit) begin
                  match_q <= 1'b0;
               end else begin
`ifdef AES_KAT_TIMEOUT_EN
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
               end
            end
            S_CHECK: begin
               if (!enable) begin
                  result_q <= '0;
               end else begin
                  result_q[ch_q] <= match_q;
                  if (ch_q != LAST_CH) ch_q <= ch_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from registered state, LEDs gated by enable
   always_comb begin
      in_done    = (state_q == S_DONE);
      core_start = (state_q == S_START) & enable;
      busy       = (state_q == S_START) | (state_q == S_WAIT) | (state_q == S_CHECK);
      done       = in_done;
      ch_sel     = ch_q;
      pass_led   = {NUM_CH{enable & in_done}} & result_q;
      all_pass   = enable & in_done & (&result_q);
   end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Scoreboard bench for aes_kat_sequencer: stimulus pushes the expected run
// outcome, a monitor pops it when done rises. Timeout scenario compiled only
// when AES_KAT_TIMEOUT_EN is defined.
module tb_aes_kat_sequencer;
   localparam int unsigned NUM_CH  = 6;
   localparam int unsigned DATA_W  = 128;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CW      = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              core_done = 1'b0;
   logic [DATA_W-1:0] core_result = '0;
   logic [DATA_W-1:0] exp_data;
   logic [CW-1:0]     ch_sel;
   logic              core_start;
   logic [NUM_CH-1:0] pass_led;
   logic              all_pass, busy, done;

   logic [DATA_W-1:0] exp_tab  [8];
   logic [DATA_W-1:0] flip_tab [8];
   bit                silent   [8];
   int unsigned       lat = 4;
   int unsigned       cyc = 0;
   int unsigned       cm_ch;
   int                n_checks = 0;
   int                n_fail = 0;

   typedef struct {
      logic [NUM_CH-1:0] leds;
      logic              allp;
      int unsigned       done_cyc;
   } exp_t;
   exp_t sb[$];

   aes_kat_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .ch_sel(ch_sel),
      .core_start(core_start), .core_done(core_done), .core_result(core_result),
      .exp_data(exp_data), .pass_led(pass_led), .all_pass(all_pass),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   assign exp_data = exp_tab[ch_sel];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Core model: answers lat+1 cycles after the start pulse is seen
   always begin
      @(negedge clk);
      if (rst_n && core_start && !silent[ch_sel]) begin
         cm_ch = ch_sel;
         repeat (lat + 1) @(posedge clk);
         #1;
         core_result = exp_tab[cm_ch] ^ flip_tab[cm_ch];
         core_done   = 1'b1;
         @(posedge clk);
         #1 core_done = 1'b0;
      end
   end

   // Monitor: on each rising done, pop and compare the expected run outcome
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (done && !prev_done) begin
         check("run_pending_at_done", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("pass_led", pass_led, e.leds);
            check("all_pass", all_pass, e.allp);
         end
      end
      prev_done = done;
   end

   // Reference model: outcome and duration computed from channel behaviour
   function automatic exp_t model(input int unsigned base);
      exp_t e;
      int unsigned total = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         e.leds[i] = (flip_tab[i] == '0) && !silent[i];
         total += silent[i] ? (TIMEOUT + 2) : (3 + lat);
      end
      e.allp     = &e.leds;
      e.done_cyc = base + total;
      return e;
   endfunction

   task automatic new_tables(input bit allow_bad);
      for (int i = 0; i < 8; i++) begin
         exp_tab[i]  = {$urandom, $urandom, $urandom, $urandom};
         flip_tab[i] = '0;
         silent[i]   = 1'b0;
         if (allow_bad && i < NUM_CH && $urandom_range(0, 2) == 0)
            flip_tab[i] = 128'd1 << $urandom_range(0, DATA_W - 1);
      end
   endtask

   task automatic enable_low(input int unsigned n);
      @(negedge clk) enable = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic start_run(input bit push);
      @(posedge clk);
      #1 enable = 1'b1;
      if (push) sb.push_back(model(cyc + 1));
   endtask

   task automatic wait_runs(input int unsigned budget);
      int unsigned n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("run_completed_in_budget", sb.size(), 0);
      sb.delete();
   endtask

   task automatic wait_ch_busy(input int unsigned ch, output bit ok);
      int unsigned n = 0;
      ok = 1'b0;
      while (!ok && n < 1000) begin
         @(negedge clk);
         n++;
         if (busy && !core_start && ch_sel == CW'(ch)) ok = 1'b1;
      end
      check("reach_channel", ok, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ch_sel"}, ch_sel, 0);
      check({tag, "_core_start"}, core_start, 0);
      check({tag, "_pass_led"}, pass_led, 0);
      check({tag, "_all_pass"}, all_pass, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      bit ok;
      int unsigned starts;
      new_tables(1'b0);

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // All channels pass, latency 4: done 42 cycles after the edge
      lat = 4;
      start_run(1'b1);
      repeat (10) @(negedge clk);
      check("busy_mid_run", busy, 1'b1);
      check("leds_dark_mid_run", pass_led, 0);
      wait_runs(200);

      // LED gating while enable is low after a passing run
      @(negedge clk) enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("gated_pass_led", pass_led, 0);
         check("gated_all_pass", all_pass, 0);
      end

      // Single failing channel (2 returns exp_data^1)
      new_tables(1'b0);
      flip_tab[2] = 128'd1;
      start_run(1'b1);
      repeat (3) @(negedge clk);
      check("leds_dark_new_run", pass_led, 0);
      check("done_low_new_run", done, 0);
      wait_runs(200);

      // Randomised runs: latency and corrupted channels vary
      for (int r = 0; r < 6; r++) begin
         enable_low($urandom_range(1, 3));
         new_tables(1'b1);
         lat = $urandom_range(1, 6);
         start_run(1'b1);
         wait_runs(300);
      end

      // Abort while waiting on channel 3
      enable_low(2);
      new_tables(1'b0);
      lat = 3;
      start_run(1'b0);
      wait_ch_busy(3, ok);
      enable = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      starts = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (core_start) starts++;
      end
      check("abort_no_start", starts, 0);

`ifdef AES_KAT_TIMEOUT_EN
      // Channel 4 never answers and is failed by the wait counter
      new_tables(1'b0);
      silent[4] = 1'b1;
      lat = $urandom_range(1, 6);
      start_run(1'b1);
      wait_runs(400);
      enable_low(2);
`endif

      // Reset during channel 1 with enable held high
      new_tables(1'b0);
      lat = $urandom_range(1, 6);
      start_run(1'b0);
      wait_ch_busy(1, ok);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(model(cyc + 1));
      @(negedge clk);
      check("restart_ch_sel", ch_sel, 0);
      check("restart_core_start", core_start, 1'b1);
      wait_runs(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
